// File: rtl/bcd_display_converter.sv
// bcd_display_converter: sequential double-dabble binary-to-BCD converter for the HEX displays
module bcd_display_converter #(
   parameter int BIN_W  = 32,
   parameter int DIGITS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [BIN_W-1:0]      bin_in,
   input  logic                  start,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  valid,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);
   localparam int INT_D = (BIN_W + 2) / 3;
   localparam int CW    = $clog2(BIN_W);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t               state;
   logic [4*INT_D-1:0]   scratch, adj;
   logic [BIN_W-1:0]     sr, last_bin;
   logic [CW-1:0]        cnt;
   logic                 pending, hi_nz;
   for (genvar g = 0; g < INT_D; g++) begin : g_adj
      assign adj[4*g+:4] = scratch[4*g+:4] >= 4'd5 ? scratch[4*g+:4] + 4'd3 : scratch[4*g+:4];
   end
   assign hi_nz = |scratch[4*INT_D-1:4*DIGITS];
   // conversion FSM: capture in IDLE, one add-3/shift per clock in SHIFT, publish result in DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         bcd_out  <= '0;
         valid    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
         pending  <= 1'b1;
         scratch  <= '0;
         sr       <= '0;
         last_bin <= '0;
         cnt      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start || pending || bin_in != last_bin) begin
               sr       <= bin_in;
               last_bin <= bin_in;
               scratch  <= '0;
               cnt      <= '0;
               pending  <= 1'b0;
               busy     <= 1'b1;
               state    <= SHIFT;
            end
            SHIFT: begin
               pending       <= pending | start;
               {scratch, sr} <= {adj, sr} << 1;
               cnt           <= cnt + 1'b1;
               if (cnt == CW'(BIN_W - 1)) state <= DONE;
            end
            DONE: begin
               pending  <= pending | start;
               overflow <= hi_nz;
               bcd_out  <= hi_nz ? {DIGITS{4'h9}} : scratch[4*DIGITS-1:0];
               valid    <= 1'b1;
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
